// File: rtl/sub1_reg_reader.sv
// Snapshot-and-stream reader for sub1's registers and byte arrays.
// Define SUB1_REG_READER_CHKSUM_EN to append an XOR checksum beat to each frame.
module sub1_reg_reader #(
    parameter int DW = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [DW-1:0]       reg_a_0,
    input  logic [DW-1:0]       reg_a_1,
    input  logic [DW-1:0]       reg_a_2,
    input  logic [DW-1:0]       reg_a_3,
    input  logic [DW-1:0]       reg_a_4,
    input  logic [DW-1:0]       reg_b_0,
    input  logic [DW-1:0]       reg_b_1,
    input  logic [DW-1:0]       reg_b_2,
    input  logic [0:2][DW-1:0]  i_sig_g,
    input  logic [DW-1:0]       i_sig_h [0:2],
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DW-1:0]       o_data,
    output logic [3:0]          o_index,
    output logic                o_last,
    output logic                o_busy,
    output logic                o_done
);
    localparam int NB = 14;
`ifdef SUB1_REG_READER_CHKSUM_EN
    localparam int FL = 15;
`else
    localparam int FL = 14;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FL - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          cap;
    logic [DW-1:0] live   [NB];
    logic [DW-1:0] snap_q [NB];
    logic [DW-1:0] frame  [16];

    always_comb begin
        live[0]  = reg_a_0;
        live[1]  = reg_a_1;
        live[2]  = reg_a_2;
        live[3]  = reg_a_3;
        live[4]  = reg_a_4;
        live[5]  = reg_b_0;
        live[6]  = reg_b_1;
        live[7]  = reg_b_2;
        live[8]  = i_sig_g[0];
        live[9]  = i_sig_g[1];
        live[10] = i_sig_g[2];
        live[11] = i_sig_h[0];
        live[12] = i_sig_h[1];
        live[13] = i_sig_h[2];
    end

    // Frame image padded to 16 so the 4-bit counter can index it directly.
    always_comb begin
        for (int i = 0; i < 16; i++) frame[i] = '0;
        for (int i = 0; i < NB; i++) frame[i] = snap_q[i];
`ifdef SUB1_REG_READER_CHKSUM_EN
        for (int i = 0; i < NB; i++) frame[NB] = frame[NB] ^ snap_q[i];
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    cap     = 1'b1;
                end
            end
            SEND: begin
                if (i_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NB; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (cap) begin
                for (int i = 0; i < NB; i++) snap_q[i] <= live[i];
            end
        end
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign o_valid = (state_q == SEND);
    assign o_busy  = (state_q == SEND);
    assign o_data  = o_valid ? frame[cnt_q] : '0;
    assign o_index = o_valid ? cnt_q : 4'd0;
    assign o_last  = o_valid && (cnt_q == LAST_IDX);
    assign o_done  = done_q;

endmodule

// File: tb/tb_sub1_reg_reader.sv
// Bench for sub1_reg_reader: frame-level model checked every cycle plus directed scenarios.
module tb_sub1_reg_reader;
`ifdef SUB1_REG_READER_CHKSUM_EN
    localparam int FL = 15;
`else
    localparam int FL = 14;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b1;
    logic            i_start = 1'b0;
    logic            i_ready = 1'b0;
    logic [7:0]      ra [5];
    logic [7:0]      rb [3];
    logic [0:2][7:0] sg;
    logic [7:0]      sh [0:2];
    logic            o_valid, o_last, o_busy, o_done;
    logic [7:0]      o_data;
    logic [3:0]      o_index;

    sub1_reg_reader #(.DW(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .reg_a_0(ra[0]), .reg_a_1(ra[1]), .reg_a_2(ra[2]), .reg_a_3(ra[3]), .reg_a_4(ra[4]),
        .reg_b_0(rb[0]), .reg_b_1(rb[1]), .reg_b_2(rb[2]),
        .i_sig_g(sg), .i_sig_h(sh),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_index(o_index),
        .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: a frame is the list of captured bytes, walked in order.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_frame [15];

    function automatic logic [7:0] live_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 5; i++) x ^= ra[i];
        for (int i = 0; i < 3; i++) x ^= rb[i] ^ sg[i] ^ sh[i];
        return x;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pos  <= 0;
            for (int i = 0; i < 15; i++) m_frame[i] <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (i_ready) begin
                    if (m_pos == FL - 1) begin
                        m_busy <= 1'b0;
                        m_pos  <= 0;
                        m_done <= 1'b1;
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
            end else if (i_start) begin
                for (int i = 0; i < 5; i++) m_frame[i] <= ra[i];
                for (int i = 0; i < 3; i++) begin
                    m_frame[5 + i]  <= rb[i];
                    m_frame[8 + i]  <= sg[i];
                    m_frame[11 + i] <= sh[i];
                end
                m_frame[14] <= (FL == 15) ? live_xor() : 8'h00;
                m_busy <= 1'b1;
                m_pos  <= 0;
            end
        end
    end

    always @(negedge i_clk) begin
        check("valid", o_valid, m_busy);
        check("busy",  o_busy,  m_busy);
        check("data",  o_data,  m_busy ? m_frame[m_pos] : 0);
        check("index", o_index, m_busy ? m_pos : 0);
        check("last",  o_last,  m_busy && (m_pos == FL - 1));
        check("done",  o_done,  m_done);
    end

    // Accepted-beat log and done-pulse count for the directed checks.
    logic [7:0] acc[$];
    int         done_cnt = 0;
    int         last_idx_seen = -1;

    always @(posedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            acc.push_back(o_data);
            if (o_last) last_idx_seen = o_index;
        end
    end

    always @(negedge i_clk) if (o_done) done_cnt++;

    logic [7:0] exp_pat [15] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20, 8'h21, 8'h22,
                                 8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h42, 8'h47};

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic set_pattern();
        for (int n = 0; n < 5; n++) ra[n] = 8'h10 + 8'(n);
        for (int n = 0; n < 3; n++) begin
            rb[n] = 8'h20 + 8'(n);
            sg[n] = 8'h30 + 8'(n);
            sh[n] = 8'h40 + 8'(n);
        end
    endtask

    task automatic set_ff();
        for (int n = 0; n < 5; n++) ra[n] = 8'hFF;
        for (int n = 0; n < 3; n++) begin
            rb[n] = 8'hFF;
            sg[n] = 8'hFF;
            sh[n] = 8'hFF;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!o_done && c < 100) begin
            tick();
            c++;
        end
        check(name, o_done, 1);
    endtask

    task automatic check_frame(input string name);
        check({name, "_beats"}, acc.size(), FL);
        for (int i = 0; i < FL && i < acc.size(); i++) check({name, "_byte"}, acc[i], exp_pat[i]);
    endtask

    initial begin
        int cyc;
        int d0;
        set_pattern();
        #1 i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_data",  o_data,  0);
        check("rst_index", o_index, 0);
        check("rst_last",  o_last,  0);
        check("rst_busy",  o_busy,  0);
        check("rst_done",  o_done,  0);

        // Basic frame, ready held high.
        i_ready = 1'b1;
        acc.delete();
        pulse_start();
        cyc = 0;
        while (!o_done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("f1_done_cycle", cyc, FL);
        check("f1_last_idx", last_idx_seen, FL - 1);
        check_frame("f1");
        tick();

        // Ready toggling, inputs trashed after the snapshot.
        acc.delete();
        pulse_start();
        set_ff();
        cyc = 0;
        while (o_busy && cyc < 100) begin
            cyc++;
            i_ready = cyc[0];
            tick();
        end
        check("f2_busy_cycles", cyc, 2 * FL - 1);
        check_frame("f2");
        i_ready = 1'b1;
        set_pattern();
        tick();

        // Starts during the frame and on the last accept are ignored; start on done begins a new frame.
        pulse_start();
        acc.delete();
        d0 = done_cnt;
        cyc = 0;
        while (o_index != 4'd5 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("f3_reach_idx5", o_index, 5);
        pulse_start();
        cyc = 0;
        while (!o_last && cyc < 50) begin
            tick();
            cyc++;
        end
        check("f3_reach_last", o_last, 1);
        i_start = 1'b1;
        tick();
        check("f3_done_pulse", o_done, 1);
        check("f3_idle_on_done", o_busy, 0);
        tick();
        i_start = 1'b0;
        check("f3_restart_busy", o_busy, 1);
        check("f3_restart_index", o_index, 0);
        check("f3_one_frame_beats", acc.size(), FL);
        check("f3_one_done", done_cnt - d0, 1);
        wait_done("f3b_done");
        tick();

        // Long stall on beat 0.
        i_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", o_valid, 1);
            check("stall_data",  o_data,  8'h10);
            check("stall_index", o_index, 0);
            tick();
        end
        i_ready = 1'b1;
        wait_done("stall_done");
        tick();

        // Reset mid-frame at index 7.
        d0 = done_cnt;
        pulse_start();
        cyc = 0;
        while (o_index != 4'd7 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("r_reach_idx7", o_index, 7);
        #1 i_rst_n = 1'b0;
        #1;
        check("r_valid", o_valid, 0);
        check("r_data",  o_data,  0);
        check("r_index", o_index, 0);
        check("r_last",  o_last,  0);
        check("r_busy",  o_busy,  0);
        check("r_done",  o_done,  0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        check("r_no_done", done_cnt - d0, 0);
        acc.delete();
        pulse_start();
        check("r_restart_index", o_index, 0);
        wait_done("r_frame_done");
        check_frame("r_frame");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
